// File: rtl/network_mac_pipe_if.sv
// network_mac_pipe_if: beat input and result output streams of the MAC pipe.
interface network_mac_pipe_if #(
    parameter int A_W   = 16,
    parameter int B_W   = 14,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [A_W-1:0]   in_a;
    logic signed [B_W-1:0]   in_b;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;
    logic [CNT_W-1:0]        out_beats;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_beats
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_beats
    );
endinterface

// File: rtl/network_mac_pipe.sv
// network_mac_pipe: pipelined signed MAC with per-group accumulation, round-half-up shift and saturation.
module network_mac_pipe #(
    parameter int A_W        = 16,
    parameter int B_W        = 14,
    parameter int ACC_W      = 40,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 14,
    parameter int MUL_STAGES = 3,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic reset_n,
    network_mac_pipe_if.slave s
);
    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(2 ** FRAC_SHIFT) >> 1;
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = ~MAXV;

    logic                      en;
    logic signed [A_W-1:0]     a_r;
    logic signed [B_W-1:0]     b_r;
    logic [MUL_STAGES-1:0]     v, l;
    logic signed [A_W+B_W-1:0] mul;
    logic signed [ACC_W-1:0]   mul_x, prod, acc;
    logic [CNT_W-1:0]          cnt;
    logic                      first, av, al;
    logic signed [ACC_W:0]     rs, r;

    assign en = !s.out_valid || s.out_ready;
    assign s.in_ready = en;
    assign mul = a_r * b_r;
    assign mul_x = ACC_W'(mul);
    assign rs = {acc[ACC_W-1], acc} + RND;
    assign r = rs >>> FRAC_SHIFT;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            v   <= '0;
            l   <= '0;
            a_r <= '0;
            b_r <= '0;
        end else if (en) begin
            v[0] <= s.in_valid;
            l[0] <= s.in_last;
            a_r  <= s.in_a;
            b_r  <= s.in_b;
            for (int i = 1; i < MUL_STAGES; i++) begin
                v[i] <= v[i-1];
                l[i] <= l[i-1];
            end
        end

    // Stage 0 registers the operands; remaining stages carry the product for DSP retiming.
    if (MUL_STAGES > 1) begin : g_pipe
        logic signed [ACC_W-1:0] p [1:MUL_STAGES-1];
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                for (int i = 1; i < MUL_STAGES; i++) p[i] <= '0;
            end else if (en) begin
                p[1] <= mul_x;
                for (int i = 2; i < MUL_STAGES; i++) p[i] <= p[i-1];
            end
        assign prod = p[MUL_STAGES-1];
    end else begin : g_comb
        assign prod = mul_x;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            acc   <= '0;
            cnt   <= '0;
            first <= 1'b1;
            av    <= 1'b0;
            al    <= 1'b0;
        end else if (en) begin
            av <= v[MUL_STAGES-1];
            al <= l[MUL_STAGES-1];
            if (v[MUL_STAGES-1]) begin
                acc   <= first ? prod : acc + prod;
                cnt   <= first ? CNT_W'(1) : cnt + 1'b1;
                first <= l[MUL_STAGES-1];
            end
        end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_sat   <= 1'b0;
            s.out_beats <= '0;
        end else if (en) begin
            s.out_valid <= av && al;
            if (av && al) begin
                s.out_data  <= r > MAXV ? MAXV[OUT_W-1:0] : r < MINV ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
                s.out_sat   <= r > MAXV || r < MINV;
                s.out_beats <= cnt;
            end
        end
endmodule
